priority_frame_scheduler: RTL

Frame-aware scheduler that drives the `select` and `enable` inputs of the N-input AXI-Stream mux behind the per-priority packet FIFOs. It grants one FIFO at a time, holds the grant for a whole frame until the `tlast` beat is accepted at the mux output, and re-arbitrates only between frames. Arbitration is strict priority, with index 0 as the highest. An optional starvation guard promotes lower-priority queues that have been bypassed for too many frames.

---
 rtl/priority_frame_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/priority_frame_scheduler.sv
// Frame-aware strict-priority scheduler driving the select/enable of an AXI-Stream mux.
// Optional starvation guard enabled by defining PFS_STARVATION_GUARD_EN.
module priority_frame_scheduler #(
    parameter int N_FIFO       = 3,
    parameter int SEL_WIDTH    = $clog2(N_FIFO),
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FIFO-1:0]    s_axis_tvalid,
    input  logic                 m_axis_mult_tvalid,
    input  logic                 m_axis_mult_tready,
    input  logic                 m_axis_mult_tlast,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 en,
    output logic [N_FIFO-1:0]    status_promoted,
    output logic                 status_frame_done
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << CNT_WIDTH)) begin : gBadLimit
        $error("STARVE_LIMIT out of range for CNT_WIDTH");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   en_q, en_d;
    logic                   frameDone_q, frameDone_d;
    logic [SEL_WIDTH-1:0]   winIdx;
    logic                   anyReq;
    logic                   frameEnd;
    logic                   grant;

`ifdef PFS_STARVATION_GUARD_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STARVE_LIMIT);

    logic [N_FIFO-1:0]      promoted_q, promoted_d;
    logic [CNT_WIDTH-1:0]   cnt_q [1:N_FIFO-1];
    logic [CNT_WIDTH-1:0]   cnt_d [1:N_FIFO-1];
    logic [N_FIFO-1:0]      promoReq;
    logic [SEL_WIDTH-1:0]   promoIdx;
`endif

    assign anyReq   = |s_axis_tvalid;
    assign frameEnd = (state_q == BUSY) && m_axis_mult_tvalid
                      && m_axis_mult_tready && m_axis_mult_tlast;

    // Promoted valid queues beat plain valid queues; lowest index wins within each class.
    always_comb begin
        winIdx = '0;
        for (int i = N_FIFO - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                winIdx = SEL_WIDTH'(i);
            end
        end
`ifdef PFS_STARVATION_GUARD_EN
        promoReq = s_axis_tvalid & promoted_q;
        promoIdx = '0;
        for (int i = N_FIFO - 1; i >= 1; i--) begin
            if (promoReq[i]) begin
                promoIdx = SEL_WIDTH'(i);
            end
        end
        if (|promoReq) begin
            winIdx = promoIdx;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        en_d        = en_q;
        frameDone_d = 1'b0;
        grant       = 1'b0;
        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                if (anyReq) begin
                    grant   = 1'b1;
                    sel_d   = winIdx;
                    en_d    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (frameEnd) begin
                    frameDone_d = 1'b1;
                    if (anyReq) begin
                        grant = 1'b1;
                        sel_d = winIdx;
                        en_d  = 1'b1;
                    end else begin
                        en_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

`ifdef PFS_STARVATION_GUARD_EN
    // A granted queue's clear takes precedence over the bypass count of the same frame end.
    always_comb begin
        promoted_d = promoted_q;
        cnt_d      = cnt_q;
        for (int i = 1; i < N_FIFO; i++) begin
            if (frameEnd && s_axis_tvalid[i] && (sel_q < SEL_WIDTH'(i))) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                if (cnt_d[i] >= LIMIT) begin
                    promoted_d[i] = 1'b1;
                end
            end
            if (grant && (winIdx == SEL_WIDTH'(i))) begin
                cnt_d[i]      = '0;
                promoted_d[i] = 1'b0;
            end
        end
        promoted_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            promoted_q <= '0;
            for (int i = 1; i < N_FIFO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            promoted_q <= promoted_d;
            for (int i = 1; i < N_FIFO; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign status_promoted = promoted_q;
`else
    assign status_promoted = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            en_q        <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign sel               = sel_q;
    assign en                = en_q;
    assign status_frame_done = frameDone_q;

endmodule
